// File: rtl/div_unit_if.sv
// div_unit_if: handshake/bus bundle between the CPU (master) and the divider (slave).
//   startdiv   : master -> slave, start request
//   diva, divb : master -> slave, dividend / divisor (two's complement)
//   divstop    : slave -> master, one-cycle result-valid pulse
//   divzero    : slave -> master, one-cycle divide-by-zero pulse
//   divbusy    : slave -> master, division in progress
//   divhighout : slave -> master, remainder (HI)
//   divlowout  : slave -> master, quotient (LO)
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             startdiv;
  logic [WIDTH-1:0] diva;
  logic [WIDTH-1:0] divb;
  logic             divstop;
  logic             divzero;
  logic             divbusy;
  logic [WIDTH-1:0] divhighout;
  logic [WIDTH-1:0] divlowout;

  modport master (
    output startdiv, diva, divb,
    input  divstop, divzero, divbusy, divhighout, divlowout
  );

  modport slave (
    input  startdiv, diva, divb,
    output divstop, divzero, divbusy, divhighout, divlowout
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: multicycle signed divider (restoring, one quotient bit per clock).
//   clock : rising-edge clock
//   reset : asynchronous, active-high; clears all state and outputs
//   bus   : div_unit_if.slave (startdiv/diva/divb in; divstop/divzero/divbusy/
//           divhighout/divlowout out). All outputs are registered.
// Quotient truncates toward zero; the remainder takes the dividend's sign.
// divstop is high in the 34th cycle after the sampling edge (WIDTH=32),
// independent of the operand values.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clock,
  input  logic       reset,
  div_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] ZERO = 2'd3;

  localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH);
  localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

  // Two's complement negation; the most negative value maps onto itself,
  // which read as unsigned is exactly its magnitude.
  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    neg = ~v + W_ONE;
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    mag = v[WIDTH-1] ? neg(v) : v;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
  logic             sgnq_q, sgnq_d;
  logic             sgnr_q, sgnr_d;
  logic             stop_q, stop_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Restoring step: the trial remainder is one bit wider than the operands so
  // that a divisor magnitude of 2^(WIDTH-1) still compares correctly.
  logic [WIDTH:0] trial_s;
  logic [WIDTH:0] diff_s;
  logic           ge_s;

  assign trial_s = {rem_q, quo_q[WIDTH-1]};
  assign diff_s  = trial_s - {1'b0, dvs_q};
  assign ge_s    = (trial_s >= {1'b0, dvs_q});

  // Next-state and datapath logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    sgnq_d  = sgnq_q;
    sgnr_d  = sgnr_q;
    stop_d  = 1'b0;
    zero_d  = 1'b0;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.startdiv) begin
          busy_d = 1'b1;
          if (bus.divb == W_ZERO) begin
            state_d = ZERO;
            zero_d  = 1'b1;
          end else begin
            state_d = RUN;
            quo_d   = mag(bus.diva);
            dvs_d   = mag(bus.divb);
            sgnq_d  = bus.diva[WIDTH-1] ^ bus.divb[WIDTH-1];
            sgnr_d  = bus.diva[WIDTH-1];
            rem_d   = W_ZERO;
            cnt_d   = CNT_ZERO;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      RUN: begin
        if (cnt_q == CNT_LAST) begin
          // All quotient bits produced: apply signs and publish.
          lo_d    = sgnq_q ? neg(quo_q) : quo_q;
          hi_d    = sgnr_q ? neg(rem_q) : rem_q;
          stop_d  = 1'b1;
          state_d = DONE;
        end else begin
          // trial_s < divisor fits in WIDTH bits when no subtraction happens.
          rem_d = ge_s ? diff_s[WIDTH-1:0] : trial_s[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], ge_s};
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      ZERO: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      quo_q   <= W_ZERO;
      rem_q   <= W_ZERO;
      dvs_q   <= W_ZERO;
      sgnq_q  <= 1'b0;
      sgnr_q  <= 1'b0;
      stop_q  <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      hi_q    <= W_ZERO;
      lo_q    <= W_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      sgnq_q  <= sgnq_d;
      sgnr_q  <= sgnr_d;
      stop_q  <= stop_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.divstop    = stop_q;
  assign bus.divzero    = zero_q;
  assign bus.divbusy    = busy_q;
  assign bus.divhighout = hi_q;
  assign bus.divlowout  = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit.
module tb_div_unit;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a start at a falling edge; returns at the falling edge after the
  // sampling edge E0 (cycle index 0).
  task automatic start_div(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.startdiv = 1'b1;
    bus.diva     = a;
    bus.divb     = b;
    @(posedge clock);
    @(negedge clock);
    bus.startdiv = 1'b0;
    bus.diva     = 32'h0;
    bus.divb     = 32'h0;
  endtask

  // Observe cycles first..40 after E0; divstop must appear only at cycle 33,
  // divbusy high exactly through cycle 33, divzero never.
  task automatic wait_done(input int first, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi, input string tag);
    int stop_at;
    int stop_cnt;
    int busy_bad;
    int zero_cnt;
    stop_at  = -1;
    stop_cnt = 0;
    busy_bad = 0;
    zero_cnt = 0;
    for (int n = first; n <= 40; n++) begin
      @(negedge clock);
      if (bus.divstop) begin
        stop_cnt++;
        if (stop_at < 0) stop_at = n;
      end
      if (bus.divzero) zero_cnt++;
      if (bus.divbusy !== (n <= 33)) busy_bad++;
    end
    check({tag, "_stop_cycle"}, 32'(stop_at), 32'd33);
    check({tag, "_stop_count"}, 32'(stop_cnt), 32'd1);
    check({tag, "_busy_bad"}, 32'(busy_bad), 32'd0);
    check({tag, "_zero_count"}, 32'(zero_cnt), 32'd0);
    check({tag, "_lo"}, bus.divlowout, exp_lo);
    check({tag, "_hi"}, bus.divhighout, exp_hi);
  endtask

  initial begin
    int stray;
    checks = 0;
    errors = 0;
    reset        = 1'b1;
    bus.startdiv = 1'b0;
    bus.diva     = 32'h0;
    bus.divb     = 32'h0;
    #1;
    check("rst_stop", {31'd0, bus.divstop}, 32'd0);
    check("rst_zero", {31'd0, bus.divzero}, 32'd0);
    check("rst_busy", {31'd0, bus.divbusy}, 32'd0);
    check("rst_lo", bus.divlowout, 32'h0);
    check("rst_hi", bus.divhighout, 32'h0);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Basic signed cases.
    start_div(32'd7, 32'd2);
    check("p72_busy0", {31'd0, bus.divbusy}, 32'd1);
    check("p72_stop0", {31'd0, bus.divstop}, 32'd0);
    wait_done(1, 32'h00000003, 32'h00000001, "p72");

    start_div(32'hFFFFFFF9, 32'd2);
    wait_done(1, 32'hFFFFFFFD, 32'hFFFFFFFF, "m72");

    start_div(32'd7, 32'hFFFFFFFE);
    wait_done(1, 32'hFFFFFFFD, 32'h00000001, "p7m2");

    start_div(32'h80000000, 32'hFFFFFFFF);
    wait_done(1, 32'h80000000, 32'h00000000, "ovf");

    start_div(32'h80000000, 32'h80000000);
    wait_done(1, 32'h00000001, 32'h00000000, "minmin");

    start_div(32'd100, 32'h80000000);
    wait_done(1, 32'h00000000, 32'd100, "small_big");

    // Divide by zero keeps the prior result.
    start_div(32'd7, 32'd2);
    wait_done(1, 32'h00000003, 32'h00000001, "pre0");
    start_div(32'd5, 32'd0);
    check("dz_zero", {31'd0, bus.divzero}, 32'd1);
    check("dz_busy", {31'd0, bus.divbusy}, 32'd1);
    check("dz_stop", {31'd0, bus.divstop}, 32'd0);
    check("dz_lo", bus.divlowout, 32'h3);
    @(negedge clock);
    check("dz_zero1", {31'd0, bus.divzero}, 32'd0);
    check("dz_busy1", {31'd0, bus.divbusy}, 32'd0);
    stray = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (bus.divstop || bus.divzero || bus.divbusy) stray++;
    end
    check("dz_quiet", 32'(stray), 32'd0);
    check("dz_lo_hold", bus.divlowout, 32'h3);
    check("dz_hi_hold", bus.divhighout, 32'h1);

    // A start while busy is ignored.
    start_div(32'd7, 32'd2);
    repeat (9) @(negedge clock);
    bus.startdiv = 1'b1;
    bus.diva     = 32'd9;
    bus.divb     = 32'd4;
    @(posedge clock);
    @(negedge clock);
    bus.startdiv = 1'b0;
    bus.diva     = 32'h0;
    bus.divb     = 32'h0;
    wait_done(11, 32'h00000003, 32'h00000001, "ign");
    start_div(32'd9, 32'd4);
    wait_done(1, 32'h00000002, 32'h00000001, "p94");

    // Asynchronous reset mid-division.
    start_div(32'd1000, 32'd3);
    repeat (14) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("ar_stop", {31'd0, bus.divstop}, 32'd0);
    check("ar_busy", {31'd0, bus.divbusy}, 32'd0);
    check("ar_lo", bus.divlowout, 32'h0);
    check("ar_hi", bus.divhighout, 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    stray = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (bus.divstop || bus.divzero || bus.divbusy) stray++;
    end
    check("ar_quiet", 32'(stray), 32'd0);
    check("ar_lo_hold", bus.divlowout, 32'h0);
    start_div(32'd100, 32'd7);
    wait_done(1, 32'd14, 32'd2, "p1007");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
